// File: rtl/fetch_sequencer_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fetch_sequencer_pkg : shared state, length codes and opcode fields   |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
package fetch_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_FETCH_OP = 3'd0,
    ST_FETCH_LO = 3'd1,
    ST_FETCH_HI = 3'd2,
    ST_HOLD     = 3'd3,
    ST_REDIRECT = 3'd4,
    ST_FAULT    = 3'd5
  } fetch_state_e;

  localparam logic [1:0] LEN_1 = 2'd1;
  localparam logic [1:0] LEN_2 = 2'd2;
  localparam logic [1:0] LEN_3 = 2'd3;

  localparam int OP_LEN_MSB = 7;
  localparam int OP_LEN_LSB = 6;

  localparam int DEFAULT_WAIT_LIMIT = 15;

  function automatic logic [1:0] op_len(input logic [7:0] op);
    logic [1:0] field;
    logic [1:0] len;
    field = op[OP_LEN_MSB:OP_LEN_LSB];
    case (field)
      2'b00:   len = LEN_1;
      2'b01:   len = LEN_2;
      default: len = LEN_3;
    endcase
    return len;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_wait_timer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fetch_wait_timer : loadable up-counter, clear wins, tc one below limit|
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
module fetch_wait_timer #(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             clr_i,
  input  logic             inc_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  input  logic [WIDTH-1:0] limit_i,
  output logic             tc_o
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (load_i) begin
      count_d = load_val_i;
    end else if (inc_i) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // Flags the increment that would make the count reach the limit.
  assign tc_o = (count_q == (limit_i - 1'b1));

endmodule
`default_nettype wire

// File: rtl/fetch_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fetch_sequencer : PC control, byte fetch, instruction assembly, jumps |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
module fetch_sequencer
  import fetch_sequencer_pkg::*;
#(
  parameter int          WAIT_LIMIT    = DEFAULT_WAIT_LIMIT,
  parameter logic [15:0] RESET_DISPLAY = 16'h0000
) (
  input  logic        CLK,
  input  logic        RST_bar,
  input  logic [15:0] PC_VALUE,
  output logic        PC_LOAD_bar,
  output logic        PC_INC,
  output logic        PC_ASSERT_bar,
  output logic        JUMP_ASSERT_bar,
  output logic [15:0] BUS_out,
  output logic        MEM_RD_bar,
  input  logic        MEM_READY,
  input  logic [7:0]  MEM_DATA,
  input  logic        JUMP,
  input  logic [15:0] JUMP_ADDR,
  output logic        INSTR_VALID,
  input  logic        INSTR_READY,
  output logic [7:0]  OPCODE,
  output logic [15:0] OPERAND,
  output logic [1:0]  INSTR_LEN,
  output logic        FAULT,
  output logic [15:0] display_value
);

  localparam logic [7:0] LIMIT_W = 8'(WAIT_LIMIT);

  fetch_state_e state_q, state_d;
  logic [7:0]   opcode_q, opcode_d;
  logic [15:0]  operand_q, operand_d;
  logic [1:0]   len_q, len_d;
  logic [15:0]  target_q, target_d;

  logic w_fetching;
  logic w_waiting;
  logic w_wait_tc;

  assign w_fetching = (state_q == ST_FETCH_OP) || (state_q == ST_FETCH_LO) ||
                      (state_q == ST_FETCH_HI);
  assign w_waiting  = RST_bar && w_fetching && !MEM_READY && !JUMP;

  fetch_wait_timer #(
    .WIDTH (8)
  ) u_wait_timer (
    .clk_i      (CLK),
    .rst_n_i    (RST_bar),
    .clr_i      (!w_waiting),
    .inc_i      (w_waiting),
    .load_i     (1'b0),
    .load_val_i (8'h00),
    .limit_i    (LIMIT_W),
    .tc_o       (w_wait_tc)
  );

  always_comb begin
    state_d   = state_q;
    opcode_d  = opcode_q;
    operand_d = operand_q;
    len_d     = len_q;
    target_d  = target_q;
    case (state_q)
      ST_FETCH_OP: begin
        if (MEM_READY) begin
          opcode_d = MEM_DATA;
          len_d    = op_len(MEM_DATA);
          state_d  = (op_len(MEM_DATA) == LEN_1) ? ST_HOLD : ST_FETCH_LO;
        end else if (w_wait_tc) begin
          state_d = ST_FAULT;
        end
      end
      ST_FETCH_LO: begin
        if (MEM_READY) begin
          operand_d[7:0] = MEM_DATA;
          state_d        = (len_q == LEN_2) ? ST_HOLD : ST_FETCH_HI;
        end else if (w_wait_tc) begin
          state_d = ST_FAULT;
        end
      end
      ST_FETCH_HI: begin
        if (MEM_READY) begin
          operand_d[15:8] = MEM_DATA;
          state_d         = ST_HOLD;
        end else if (w_wait_tc) begin
          state_d = ST_FAULT;
        end
      end
      ST_HOLD: begin
        if (INSTR_READY) begin
          state_d = ST_FETCH_OP;
        end
      end
      ST_REDIRECT: state_d = ST_FETCH_OP;
      ST_FAULT:    state_d = ST_FAULT;
      default:     state_d = ST_FETCH_OP;
    endcase
    // A jump overrides any fetch, hold or timeout decision made above.
    if (JUMP && (state_q != ST_REDIRECT) && (state_q != ST_FAULT)) begin
      state_d  = ST_REDIRECT;
      target_d = JUMP_ADDR;
    end
    if (state_d == ST_FETCH_OP) begin
      operand_d = '0;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_bar) begin
      state_q   <= ST_FETCH_OP;
      opcode_q  <= '0;
      operand_q <= '0;
      len_q     <= '0;
      target_q  <= '0;
    end else begin
      state_q   <= state_d;
      opcode_q  <= opcode_d;
      operand_q <= operand_d;
      len_q     <= len_d;
      target_q  <= target_d;
    end
  end

  // Strobes stay inactive while reset is held, even though the state is FETCH_OP.
  always_comb begin
    PC_LOAD_bar     = 1'b1;
    PC_INC          = 1'b0;
    PC_ASSERT_bar   = 1'b1;
    JUMP_ASSERT_bar = 1'b1;
    MEM_RD_bar      = 1'b1;
    BUS_out         = '0;
    INSTR_VALID     = 1'b0;
    if (RST_bar) begin
      if (w_fetching) begin
        MEM_RD_bar    = 1'b0;
        PC_ASSERT_bar = 1'b0;
        PC_INC        = MEM_READY;
      end else if (state_q == ST_HOLD) begin
        INSTR_VALID = 1'b1;
      end else if (state_q == ST_REDIRECT) begin
        JUMP_ASSERT_bar = 1'b0;
        PC_LOAD_bar     = 1'b0;
        BUS_out         = target_q;
      end
    end
  end

  assign OPCODE        = opcode_q;
  assign OPERAND       = operand_q;
  assign INSTR_LEN     = len_q;
  assign FAULT         = (state_q == ST_FAULT);
  assign display_value = FAULT ? RESET_DISPLAY : PC_VALUE;

endmodule
`default_nettype wire

// File: tb/tb_fetch_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_fetch_sequencer : PC register + memory environment, scenario tests |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
module tb_fetch_sequencer;

  logic        CLK = 1'b0;
  logic        RST_bar;
  logic [15:0] pc;
  logic        PC_LOAD_bar, PC_INC, PC_ASSERT_bar, JUMP_ASSERT_bar, MEM_RD_bar;
  logic [15:0] BUS_out;
  logic        MEM_READY;
  logic [7:0]  MEM_DATA;
  logic        JUMP;
  logic [15:0] JUMP_ADDR;
  logic        INSTR_VALID, INSTR_READY, FAULT;
  logic [7:0]  OPCODE;
  logic [15:0] OPERAND, display_value;
  logic [1:0]  INSTR_LEN;

  fetch_sequencer #(
    .WAIT_LIMIT    (15),
    .RESET_DISPLAY (16'hD15A)
  ) dut (
    .CLK (CLK), .RST_bar (RST_bar), .PC_VALUE (pc),
    .PC_LOAD_bar (PC_LOAD_bar), .PC_INC (PC_INC), .PC_ASSERT_bar (PC_ASSERT_bar),
    .JUMP_ASSERT_bar (JUMP_ASSERT_bar), .BUS_out (BUS_out), .MEM_RD_bar (MEM_RD_bar),
    .MEM_READY (MEM_READY), .MEM_DATA (MEM_DATA), .JUMP (JUMP), .JUMP_ADDR (JUMP_ADDR),
    .INSTR_VALID (INSTR_VALID), .INSTR_READY (INSTR_READY), .OPCODE (OPCODE),
    .OPERAND (OPERAND), .INSTR_LEN (INSTR_LEN), .FAULT (FAULT),
    .display_value (display_value)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [7:0]  op;
    logic [15:0] opd;
    logic [1:0]  len;
  } instr_t;

  logic [7:0] mem [0:65535];
  int  n_tests = 0;
  int  n_fail  = 0;
  int  waited = 0, cur_wait = 0, fixed_wait = 0;
  bit  wait_rand = 0, mem_en = 1;
  int  inc_count = 0, hs_count = 0, bus_conflicts = 0;
  bit  last_hs;
  logic [7:0]  last_op;
  logic [15:0] last_opd;
  logic [1:0]  last_len;

  // One clock cycle: memory responds, the PC register model follows the controls.
  task automatic tick();
    logic        rd_bar_s, acc_s;
    logic [15:0] pc_n;
    #1;
    MEM_DATA  = mem[pc];
    MEM_READY = mem_en && !MEM_RD_bar && (waited >= cur_wait);
    #1;
    if (!PC_ASSERT_bar && !JUMP_ASSERT_bar) bus_conflicts++;
    if (PC_INC) inc_count++;
    last_hs  = INSTR_VALID && INSTR_READY;
    last_op  = OPCODE;
    last_opd = OPERAND;
    last_len = INSTR_LEN;
    if (last_hs) hs_count++;
    rd_bar_s = MEM_RD_bar;
    acc_s    = !MEM_RD_bar && MEM_READY;
    pc_n     = !PC_LOAD_bar ? BUS_out : (PC_INC ? pc + 16'd1 : pc);
    @(posedge CLK);
    #1;
    pc        = pc_n;
    MEM_READY = 1'b0;
    if (acc_s || rd_bar_s) begin
      waited   = 0;
      cur_wait = wait_rand ? int'($urandom_range(0, 3)) : fixed_wait;
    end else begin
      waited++;
    end
  endtask

  task automatic test_reset();
    RST_bar = 1'b0; JUMP = 1'b0; JUMP_ADDR = 16'h0; INSTR_READY = 1'b0;
    MEM_READY = 1'b0; MEM_DATA = 8'h0; pc = 16'h0;
    tick(); tick();
    n_tests++;
    if ({PC_LOAD_bar, PC_INC, PC_ASSERT_bar, JUMP_ASSERT_bar, MEM_RD_bar, INSTR_VALID, FAULT} !== 7'b1011100) begin
      n_fail++; $display("FAIL reset_strobes: got %b expected 1011100",
        {PC_LOAD_bar, PC_INC, PC_ASSERT_bar, JUMP_ASSERT_bar, MEM_RD_bar, INSTR_VALID, FAULT});
    end
    n_tests++;
    if ({BUS_out, OPCODE, OPERAND, INSTR_LEN} !== 42'h0) begin
      n_fail++; $display("FAIL reset_data: bus=%h op=%h opd=%h len=%0d expected all zero",
        BUS_out, OPCODE, OPERAND, INSTR_LEN);
    end
    n_tests++;
    if (display_value !== pc) begin
      n_fail++; $display("FAIL reset_display: got %h expected %h", display_value, pc);
    end
  endtask

  task automatic test_one_byte();
    mem[16'h0000] = 8'h05;
    fixed_wait = 0; cur_wait = 0; waited = 0; inc_count = 0;
    RST_bar = 1'b1;
    tick();
    n_tests++;
    if ({INSTR_VALID, OPCODE, INSTR_LEN, OPERAND} !== {1'b1, 8'h05, 2'd1, 16'h0000}) begin
      n_fail++; $display("FAIL one_byte_instr: valid=%b op=%h len=%0d opd=%h expected 1 05 1 0000",
        INSTR_VALID, OPCODE, INSTR_LEN, OPERAND);
    end
    n_tests++;
    if (inc_count !== 1 || pc !== 16'h0001) begin
      n_fail++; $display("FAIL one_byte_pc: incs=%0d pc=%h expected 1 0001", inc_count, pc);
    end
    INSTR_READY = 1'b1;
    tick();
    INSTR_READY = 1'b0;
  endtask

  task automatic test_three_byte_wait();
    int cycles = 0;
    int unstable = 0;
    mem[16'h0001] = 8'h8A; mem[16'h0002] = 8'h34; mem[16'h0003] = 8'h12;
    fixed_wait = 2; cur_wait = 2; waited = 0; inc_count = 0;
    while (!INSTR_VALID && cycles < 40) begin
      tick();
      cycles++;
    end
    n_tests++;
    if (cycles !== 9) begin
      n_fail++; $display("FAIL three_byte_latency: got %0d cycles expected 9", cycles);
    end
    n_tests++;
    if ({OPCODE, OPERAND, INSTR_LEN} !== {8'h8A, 16'h1234, 2'd3} || inc_count !== 3) begin
      n_fail++; $display("FAIL three_byte_instr: op=%h opd=%h len=%0d incs=%0d expected 8a 1234 3 3",
        OPCODE, OPERAND, INSTR_LEN, inc_count);
    end
    for (int i = 0; i < 10; i++) begin
      tick();
      if ({INSTR_VALID, OPCODE, OPERAND, INSTR_LEN} !== {1'b1, 8'h8A, 16'h1234, 2'd3}) unstable++;
    end
    n_tests++;
    if (unstable !== 0 || pc !== 16'h0004) begin
      n_fail++; $display("FAIL three_byte_hold: unstable=%0d pc=%h expected 0 0004", unstable, pc);
    end
    INSTR_READY = 1'b1;
    tick();
    INSTR_READY = 1'b0;
  endtask

  task automatic test_jump_mid_fetch();
    int cycles = 0;
    mem[16'h0004] = 8'h40;
    mem[16'hC000] = 8'h00;
    cur_wait = 0; fixed_wait = 5;
    tick();
    n_tests++;
    if ({MEM_RD_bar, INSTR_VALID, pc} !== {1'b0, 1'b0, 16'h0005}) begin
      n_fail++; $display("FAIL jump_setup: rd_bar=%b valid=%b pc=%h expected 0 0 0005",
        MEM_RD_bar, INSTR_VALID, pc);
    end
    JUMP = 1'b1; JUMP_ADDR = 16'hC000;
    tick();
    n_tests++;
    if ({PC_LOAD_bar, JUMP_ASSERT_bar, PC_ASSERT_bar, MEM_RD_bar, PC_INC, INSTR_VALID} !== 6'b001100 ||
        BUS_out !== 16'hC000) begin
      n_fail++; $display("FAIL jump_redirect: ctl=%b bus=%h expected 001100 c000",
        {PC_LOAD_bar, JUMP_ASSERT_bar, PC_ASSERT_bar, MEM_RD_bar, PC_INC, INSTR_VALID}, BUS_out);
    end
    JUMP_ADDR = 16'hBEEF; fixed_wait = 0;
    tick();
    JUMP = 1'b0;
    n_tests++;
    if ({JUMP_ASSERT_bar, PC_LOAD_bar, MEM_RD_bar} !== 3'b110 || pc !== 16'hC000) begin
      n_fail++; $display("FAIL jump_in_redirect: ctl=%b pc=%h expected 110 c000",
        {JUMP_ASSERT_bar, PC_LOAD_bar, MEM_RD_bar}, pc);
    end
    while (!INSTR_VALID && cycles < 20) begin
      tick();
      cycles++;
    end
    n_tests++;
    if ({INSTR_VALID, OPCODE, OPERAND, INSTR_LEN} !== {1'b1, 8'h00, 16'h0000, 2'd1} || cycles !== 1) begin
      n_fail++; $display("FAIL jump_target_instr: valid=%b op=%h opd=%h len=%0d cycles=%0d expected 1 00 0000 1 1",
        INSTR_VALID, OPCODE, OPERAND, INSTR_LEN, cycles);
    end
  endtask

  task automatic test_jump_with_handshake();
    int hs0;
    hs0 = hs_count;
    INSTR_READY = 1'b1; JUMP = 1'b1; JUMP_ADDR = 16'h2000;
    tick();
    n_tests++;
    if ({JUMP_ASSERT_bar, INSTR_VALID} !== 2'b00 || BUS_out !== 16'h2000) begin
      n_fail++; $display("FAIL jump_hs_redirect: jab=%b valid=%b bus=%h expected 0 0 2000",
        JUMP_ASSERT_bar, INSTR_VALID, BUS_out);
    end
    INSTR_READY = 1'b0; JUMP_ADDR = 16'h3000;
    tick();
    JUMP = 1'b0;
    n_tests++;
    if (JUMP_ASSERT_bar !== 1'b1 || pc !== 16'h2000 || (hs_count - hs0) !== 1) begin
      n_fail++; $display("FAIL jump_hs_single: jab=%b pc=%h handshakes=%0d expected 1 2000 1",
        JUMP_ASSERT_bar, pc, hs_count - hs0);
    end
  endtask

  task automatic test_random_stream(input logic [15:0] base, input int n);
    instr_t      exp_q[$];
    instr_t      e;
    logic [15:0] a;
    logic [7:0]  op;
    int          len, total, got, cycles;
    for (int k = 0; k < 3 * n; k++) mem[base + 16'(k)] = 8'($urandom);
    a = base; total = 0;
    for (int i = 0; i < n; i++) begin
      op  = mem[a];
      len = (op[7:6] == 2'b00) ? 1 : ((op[7:6] == 2'b01) ? 2 : 3);
      e.op  = op;
      e.len = 2'(len);
      e.opd = 16'h0000;
      if (len >= 2) e.opd[7:0]  = mem[a + 16'd1];
      if (len == 3) e.opd[15:8] = mem[a + 16'd2];
      exp_q.push_back(e);
      a = a + 16'(len);
      total += len;
    end
    INSTR_READY = 1'b0; JUMP = 1'b1; JUMP_ADDR = base;
    tick();
    JUMP = 1'b0;
    tick();
    inc_count = 0; wait_rand = 1; got = 0; cycles = 0;
    while (got < n && cycles < 3000) begin
      INSTR_READY = 1'($urandom_range(0, 1));
      tick();
      cycles++;
      if (last_hs) begin
        e = exp_q.pop_front();
        got++;
        n_tests++;
        if ({last_op, last_opd, last_len} !== {e.op, e.opd, e.len}) begin
          n_fail++; $display("FAIL random_instr[%0d]: got op=%h opd=%h len=%0d expected op=%h opd=%h len=%0d",
            got, last_op, last_opd, last_len, e.op, e.opd, e.len);
        end
      end
    end
    INSTR_READY = 1'b0; wait_rand = 0;
    n_tests++;
    if (got !== n) begin
      n_fail++; $display("FAIL random_timeout: got %0d instructions expected %0d", got, n);
    end
    n_tests++;
    if (pc !== base + 16'(total) || inc_count !== total) begin
      n_fail++; $display("FAIL random_pc: pc=%h incs=%0d expected %h %0d",
        pc, inc_count, base + 16'(total), total);
    end
  endtask

  task automatic test_fault();
    mem_en = 1'b0;
    JUMP = 1'b1; JUMP_ADDR = 16'h1234;
    tick();
    JUMP = 1'b0;
    tick();
    repeat (14) tick();
    n_tests++;
    if ({FAULT, MEM_RD_bar} !== 2'b00) begin
      n_fail++; $display("FAIL fault_early: fault=%b rd_bar=%b expected 0 0", FAULT, MEM_RD_bar);
    end
    tick();
    n_tests++;
    if ({FAULT, MEM_RD_bar, PC_ASSERT_bar, PC_INC, INSTR_VALID} !== 5'b11100 || display_value !== 16'hD15A) begin
      n_fail++; $display("FAIL fault_entry: ctl=%b disp=%h expected 11100 d15a",
        {FAULT, MEM_RD_bar, PC_ASSERT_bar, PC_INC, INSTR_VALID}, display_value);
    end
    JUMP = 1'b1; JUMP_ADDR = 16'h5555;
    repeat (3) tick();
    JUMP = 1'b0;
    n_tests++;
    if ({FAULT, JUMP_ASSERT_bar, PC_LOAD_bar} !== 3'b111 || pc !== 16'h1234) begin
      n_fail++; $display("FAIL fault_sticky: ctl=%b pc=%h expected 111 1234",
        {FAULT, JUMP_ASSERT_bar, PC_LOAD_bar}, pc);
    end
    RST_bar = 1'b0;
    tick();
    RST_bar = 1'b1;
    #1;
    n_tests++;
    if ({FAULT, MEM_RD_bar} !== 2'b00 || display_value !== 16'h1234) begin
      n_fail++; $display("FAIL fault_reset: fault=%b rd_bar=%b disp=%h expected 0 0 1234",
        FAULT, MEM_RD_bar, display_value);
    end
    mem_en = 1'b1;
  endtask

  task automatic test_bus_exclusive();
    n_tests++;
    if (bus_conflicts !== 0) begin
      n_fail++; $display("FAIL bus_exclusive: %0d conflicting cycles expected 0", bus_conflicts);
    end
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    test_reset();
    test_one_byte();
    test_three_byte_wait();
    test_jump_mid_fetch();
    test_jump_with_handshake();
    test_random_stream(16'($urandom_range(16'h0100, 16'hE000)), 30);
    test_random_stream(16'hFFF8, 20);
    test_fault();
    test_bus_exclusive();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
